// File: rtl/wb_config_pkg.sv
// Shared definitions for the Wishbone configuration loader: register
// offsets, FSM state encoding and the effective bit-count helper.
package wb_config_pkg;

  localparam logic [31:0] CFG_STATUS_OFF = 32'd0;
  localparam logic [31:0] CFG_COUNT_OFF  = 32'd1;
  localparam logic [31:0] CFG_DATA_OFF   = 32'd2;

  localparam int CFG_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } cfg_state_e;

  // A stored count above one byte's worth of bits saturates to a full byte.
  function automatic logic [3:0] eff_count(input logic [CFG_BYTE_BITS-1:0] c);
    if (c > CFG_BYTE_BITS[CFG_BYTE_BITS-1:0]) return 4'(CFG_BYTE_BITS);
    else return c[3:0];
  endfunction

endpackage

// File: rtl/cfg_col_shifter.sv
// One column's configuration serializer: loads a payload byte and a bit
// count, then emits the byte LSB-first while the count is non-zero.
module cfg_col_shifter
  import wb_config_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [CFG_BYTE_BITS-1:0] payload,
  input  logic [3:0]               bits,
  output logic                     en,
  output logic                     data
);

  logic [CFG_BYTE_BITS-1:0] sr_q;
  logic [3:0]               rem_q;

  // Load on a DATA write, otherwise shift right once per remaining bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else if (load) begin
      sr_q  <= payload;
      rem_q <= bits;
    end else if (rem_q != 4'd0) begin
      sr_q  <= sr_q >> 1;
      rem_q <= rem_q - 4'd1;
    end
  end

  // Serial bit is gated so the chain never sees stale data while idle.
  assign en   = (rem_q != 4'd0);
  assign data = en & sr_q[0];

endmodule

// File: rtl/wb_config_loader.sv
// Wishbone slave that turns 32-bit DATA writes into per-column serial
// configuration streams (byte lane k drives column k).
// Optional feature macro: WB_CONFIG_READBACK_EN -- when defined, STATUS and
// COUNT are readable; otherwise every read returns 0 and the read path is
// removed.
module wb_config_loader
  import wb_config_pkg::*;
#(
  parameter int          MX        = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_addr_i,
  input  logic [31:0]   wbs_data_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_data_o,
  output logic [MX-1:0] cfg_en,
  output logic [MX-1:0] cfg_data
);

  cfg_state_e state_q, state_d;
  logic [3:0] cyc_cnt_q, cyc_cnt_d;

  logic [MX-1:0][CFG_BYTE_BITS-1:0] count_q;
  logic [MX-1:0][3:0]               eff;
  logic [3:0]                       max_eff;

  logic req, idle_req, busy, load;
  logic hit_status, hit_count, hit_data;

  assign req        = wbs_cyc_i & wbs_stb_i;
  assign idle_req   = (state_q == IDLE) & req;
  assign busy       = (state_q != IDLE);
  assign hit_status = (wbs_addr_i == BASE_ADDR + CFG_STATUS_OFF);
  assign hit_count  = (wbs_addr_i == BASE_ADDR + CFG_COUNT_OFF);
  assign hit_data   = (wbs_addr_i == BASE_ADDR + CFG_DATA_OFF);

  // Effective per-column counts and their maximum, which sets the shift length.
  always_comb begin
    max_eff = '0;
    for (int k = 0; k < MX; k++) begin
      eff[k] = eff_count(count_q[k]);
      if (eff[k] > max_eff) max_eff = eff[k];
    end
  end

  // Per-column bit counts; only selected lanes are updated.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < MX; k++) count_q[k] <= 8'(CFG_BYTE_BITS);
    end else if (idle_req && wbs_we_i && hit_count) begin
      for (int k = 0; k < MX; k++)
        if (wbs_sel_i[k]) count_q[k] <= wbs_data_i[8*k +: 8];
    end
  end

  // State and global shift-cycle counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  // Next-state logic; a DATA write always loads the shifters, even when every
  // count is zero, since a zero count keeps that column's enable low anyway.
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          load = wbs_we_i & hit_data;
          if (wbs_we_i && hit_data && max_eff != 4'd0) begin
            state_d   = SHIFT;
            cyc_cnt_d = max_eff;
          end else begin
            state_d = ACK;
          end
        end
      end
      SHIFT: begin
        cyc_cnt_d = cyc_cnt_q - 4'd1;
        if (cyc_cnt_q == 4'd1) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack only while the master still holds the request, so a cycle abandoned
  // mid-shift finishes silently.
  assign wbs_ack_o = (state_q == ACK) & req;

  for (genvar k = 0; k < MX; k++) begin : g_col
    cfg_col_shifter u_col (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .load    (load),
      .payload (wbs_data_i[8*k +: 8]),
      .bits    (eff[k]),
      .en      (cfg_en[k]),
      .data    (cfg_data[k])
    );
  end

`ifdef WB_CONFIG_READBACK_EN
  logic [31:0] cnt_word, rd_mux, rdata_q;

  // Lanes without a column read back as a full-byte count.
  for (genvar k = 0; k < 4; k++) begin : g_rb
    if (k < MX) begin : g_live
      assign cnt_word[8*k +: 8] = count_q[k];
    end else begin : g_tie
      assign cnt_word[8*k +: 8] = 8'(CFG_BYTE_BITS);
    end
  end

  // Read mux over the readable registers.
  always_comb begin
    rd_mux = '0;
    if (hit_status)     rd_mux = {31'd0, busy};
    else if (hit_count) rd_mux = cnt_word;
  end

  // Read data captured at request sampling, presented during ACK.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)              rdata_q <= '0;
    else if (idle_req)         rdata_q <= wbs_we_i ? 32'd0 : rd_mux;
    else if (state_q == ACK)   rdata_q <= '0;
  end

  assign wbs_data_o = rdata_q;

  logic unused_in;
  assign unused_in = ^{wbs_data_i, wbs_sel_i};
`else
  assign wbs_data_o = '0;

  logic unused_in;
  assign unused_in = ^{wbs_data_i, wbs_sel_i, busy, hit_status};
`endif

endmodule

// File: tb/tb_wb_config_loader.sv
// Directed bench for wb_config_loader (MX=3). Readback expectations follow
// WB_CONFIG_READBACK_EN: reads return 0 when it is undefined.
module tb_wb_config_loader;

  localparam int          MX   = 3;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_CONFIG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = '0;
  logic [31:0]   addr = '0, wdat = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [MX-1:0] en, dat;

  int          n_run = 0, n_fail = 0;
  int          ack_cyc;
  logic [31:0] rd;
  int          en_cnt [MX];
  logic [7:0]  stream [MX];

  always #5 clk = ~clk;

  wb_config_loader #(.MX(MX), .BASE_ADDR(BASE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_addr_i (addr),
    .wbs_data_i (wdat),
    .wbs_ack_o  (ack),
    .wbs_data_o (rdat),
    .cfg_en     (en),
    .cfg_data   (dat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rbv(input logic [31:0] v);
    return RB ? v : 32'd0;
  endfunction

  // One bus access started just after a rising edge. Cycle 1 is the cycle
  // after the request is sampled; logs enables/bits until ack (bounded).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    ack_cyc = -1;
    rd      = '0;
    for (int k = 0; k < MX; k++) begin
      en_cnt[k] = 0;
      stream[k] = '0;
    end
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < MX; k++) begin
        if (en[k]) en_cnt[k]++;
        if (c <= 8) stream[k][c-1] = dat[k];
      end
      if (ack) begin
        ack_cyc = c;
        rd      = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   32'(ack),  32'd0);
    chk("rst_rdata", rdat,      32'd0);
    chk("rst_en",    32'(en),   32'd0);
    chk("rst_data",  32'(dat),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // COUNT readback after reset
    xfer(1'b0, BASE + 32'd1, 32'd0, 4'hF);
    chk("rd_count_ack", 32'(ack_cyc), 32'd1);
    chk("rd_count",     rd,           rbv(32'h0808_0808));

    // STATUS idle
    xfer(1'b0, BASE, 32'd0, 4'hF);
    chk("rd_status_ack", 32'(ack_cyc), 32'd1);
    chk("rd_status",     rd,           32'd0);

    // Partial-lane COUNT write
    xfer(1'b1, BASE + 32'd1, 32'h0000_0200, 4'b0010);
    chk("wr_sel_ack", 32'(ack_cyc), 32'd1);
    xfer(1'b0, BASE + 32'd1, 32'd0, 4'hF);
    chk("rd_sel", rd, rbv(32'h0808_0208));

    // Column 1 now has count 2; check that shortens only column 1
    xfer(1'b1, BASE + 32'd2, 32'h00FF_FFFF, 4'hF);
    chk("part_ack",  32'(ack_cyc),  32'd9);
    chk("part_en1",  32'(en_cnt[1]), 32'd2);
    chk("part_s1",   32'(stream[1]), 32'h03);

    // Full-byte DATA write with all counts at 8
    xfer(1'b1, BASE + 32'd1, 32'h0808_0808, 4'hF);
    xfer(1'b1, BASE + 32'd2, 32'h00C3_5AA5, 4'h0);
    chk("d8_ack", 32'(ack_cyc), 32'd9);
    chk("d8_en0", 32'(en_cnt[0]), 32'd8);
    chk("d8_en1", 32'(en_cnt[1]), 32'd8);
    chk("d8_en2", 32'(en_cnt[2]), 32'd8);
    chk("d8_s0",  32'(stream[0]), 32'hA5);
    chk("d8_s1",  32'(stream[1]), 32'h5A);
    chk("d8_s2",  32'(stream[2]), 32'hC3);

    // Mixed counts, including zero and a saturating 0xFF on an unused lane
    xfer(1'b1, BASE + 32'd1, 32'hFF03_0500, 4'hF);
    xfer(1'b1, BASE + 32'd2, 32'h00FF_FFFF, 4'hF);
    chk("mix_ack", 32'(ack_cyc), 32'd6);
    chk("mix_en0", 32'(en_cnt[0]), 32'd0);
    chk("mix_en1", 32'(en_cnt[1]), 32'd5);
    chk("mix_en2", 32'(en_cnt[2]), 32'd3);
    chk("mix_s1",  32'(stream[1]), 32'h1F);
    chk("mix_s2",  32'(stream[2]), 32'h07);

    // Saturation: count 0x20 means 8 bits
    xfer(1'b1, BASE + 32'd1, 32'h0000_2000, 4'b0010);
    xfer(1'b1, BASE + 32'd2, 32'h0000_FF00, 4'hF);
    chk("sat_ack", 32'(ack_cyc),  32'd9);
    chk("sat_en1", 32'(en_cnt[1]), 32'd8);

    // All effective counts zero: immediate ack, no shifting
    xfer(1'b1, BASE + 32'd1, 32'hFF00_0000, 4'hF);
    xfer(1'b1, BASE + 32'd2, 32'hFFFF_FFFF, 4'hF);
    chk("zero_ack", 32'(ack_cyc), 32'd1);
    chk("zero_en",  32'(en_cnt[0] + en_cnt[1] + en_cnt[2]), 32'd0);

    // Reset during the 3rd shift cycle aborts the shift without an ack
    xfer(1'b1, BASE + 32'd1, 32'h0808_0808, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE + 32'd2; wdat = 32'h00FF_FFFF; sel = 4'hF;
    @(posedge clk); #1;
    chk("rs_en_c1", 32'(en), 32'h7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rs_en_c4", 32'(en), 32'd0);
    acks = int'(ack);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      acks += int'(ack);
    end
    chk("rs_no_ack", 32'(acks), 32'd0);
    xfer(1'b0, BASE, 32'd0, 4'hF);
    chk("rs_status_ack", 32'(ack_cyc), 32'd1);
    chk("rs_status",     rd,           32'd0);
    xfer(1'b0, BASE + 32'd1, 32'd0, 4'hF);
    chk("rs_count", rd, rbv(32'h0808_0808));

    // Unmapped address: acked, no effect
    xfer(1'b1, BASE + 32'd7, 32'h1234_5678, 4'hF);
    chk("bad_ack", 32'(ack_cyc), 32'd1);
    chk("bad_en",  32'(en_cnt[0] + en_cnt[1] + en_cnt[2]), 32'd0);
    xfer(1'b0, BASE + 32'd1, 32'd0, 4'hF);
    chk("bad_count", rd, rbv(32'h0808_0808));
    xfer(1'b1, BASE + 32'd2, 32'h0000_0001, 4'hF);
    chk("bad_len", 32'(ack_cyc), 32'd9);
    chk("bad_s0",  32'(stream[0]), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
